// File: rtl/cont_readout_pkg.sv
// -----------------------------------------------------------------------------
// cont_readout_pkg
//    Shared types and constants for the continuous-readout sequencer.
//    ro_state_t   : readout engine states
//    bank_t       : counter bank identifier (A = 0, B = 1)
//    MIN_FRAME_LEN: shortest exposure the shutter timer will run
// -----------------------------------------------------------------------------
package cont_readout_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PRESENT, DONE} ro_state_t;

   typedef enum logic {BANK_A, BANK_B} bank_t;

   localparam int MIN_FRAME_LEN = 2;

endpackage

// File: rtl/cont_shutter_timer.sv
// -----------------------------------------------------------------------------
// cont_shutter_timer
//    Ping-pong exposure timer for counter banks A/B. One bank counts behind its
//    shutter while the readout engine drains the other one.
// Ports
//    readClk      in   clock, rising edge
//    reset        in   synchronous, active-high
//    enable       in   continuous-acquisition enable
//    frameLen     in   exposure length in cycles (values below 2 run as 2)
//    engineIdle   in   readout engine is in IDLE this cycle
//    pendingTake  in   engine is claiming the pending bank this cycle
//    shutterA/B   out  counting windows
//    overrun      out  sticky: a swap had to wait for the engine
//    pending      out  a closed bank is waiting for readout
//    pendingBank  out  which bank is waiting
// -----------------------------------------------------------------------------
module cont_shutter_timer
   import cont_readout_pkg::*;
#(
   parameter int FrameW = 16
) (
   input  logic              readClk,
   input  logic              reset,
   input  logic              enable,
   input  logic [FrameW-1:0] frameLen,
   input  logic              engineIdle,
   input  logic              pendingTake,
   output logic              shutterA,
   output logic              shutterB,
   output logic              overrun,
   output logic              pending,
   output bank_t             pendingBank
);

   logic [FrameW-1:0] expCnt;
   logic [FrameW-1:0] startCnt;
   logic              deadCycle;
   logic              exposing;
   logic              canSwap;
   bank_t             activeBank;

   // The counter is loaded with length-1 and the expiry is the cycle in which
   // it reads zero, so the shutter stays high for exactly the clamped length.
   // A swap is only allowed when the engine is idle and nothing is queued,
   // which keeps a single pending slot sufficient.
   always_comb begin
      startCnt = (frameLen < FrameW'(MIN_FRAME_LEN)) ? FrameW'(MIN_FRAME_LEN - 1)
                                                     : frameLen - FrameW'(1);
      exposing = shutterA | shutterB;
      canSwap  = engineIdle && !pending;
   end

   // Exposure sequencing: expose, then one dead cycle with both shutters low,
   // then the other bank. A blocked expiry simply leaves the counter at zero,
   // so the same expiry branch retries every cycle until the engine frees up.
   // Dropping enable closes the current bank immediately as the final frame.
   always_ff @(posedge readClk) begin
      if (reset) begin
         shutterA    <= 1'b0;
         shutterB    <= 1'b0;
         overrun     <= 1'b0;
         pending     <= 1'b0;
         pendingBank <= BANK_A;
         activeBank  <= BANK_A;
         deadCycle   <= 1'b0;
         expCnt      <= '0;
      end else begin
         if (pendingTake)
            pending <= 1'b0;
         if (!enable && engineIdle)
            overrun <= 1'b0;
         if (exposing) begin
            if (!enable) begin
               shutterA    <= 1'b0;
               shutterB    <= 1'b0;
               pending     <= 1'b1;
               pendingBank <= activeBank;
            end else if (expCnt != '0) begin
               expCnt <= expCnt - FrameW'(1);
            end else if (canSwap) begin
               shutterA    <= 1'b0;
               shutterB    <= 1'b0;
               deadCycle   <= 1'b1;
               pending     <= 1'b1;
               pendingBank <= activeBank;
            end else begin
               overrun <= 1'b1;
            end
         end else if (deadCycle) begin
            deadCycle <= 1'b0;
            if (enable) begin
               activeBank <= (activeBank == BANK_A) ? BANK_B : BANK_A;
               shutterA   <= (activeBank == BANK_B);
               shutterB   <= (activeBank == BANK_A);
               expCnt     <= startCnt;
            end
         end else if (enable) begin
            activeBank <= BANK_A;
            shutterA   <= 1'b1;
            expCnt     <= startCnt;
         end
      end
   end

endmodule

// File: rtl/cont_readout_ctrl.sv
// -----------------------------------------------------------------------------
// cont_readout_ctrl
//    Continuous-readout sequencer for the dig_fe pixel array. Ping-pongs the
//    A/B counter banks, shifts the closed bank out of the per-column serial
//    chains and presents one row word at a time on a valid/ready stream.
// Ports
//    readClk, reset        clock and synchronous active-high reset
//    enable, frameLen      acquisition enable and exposure length
//    shutterA/B            bank counting windows
//    loadChain, shiftEn    chain parallel-load pulse and shift enable
//    bankSel               bank being read, also selects serOutA/serOutB
//    serOutA/B             per-column chain outputs
//    dataOut, rowIdx,
//    frameId, dataValid,
//    dataReady             row-word stream to the periphery FIFO
//    overrun, busy         sticky swap-held flag, engine not idle
// -----------------------------------------------------------------------------
module cont_readout_ctrl
   import cont_readout_pkg::*;
#(
   parameter  int Row      = 2,
   parameter  int Col      = 2,
   parameter  int CntWidth = 12,
   parameter  int FrameW   = 16,
   parameter  int FrameIdW = 8,
   localparam int RowW     = (Row > 1) ? $clog2(Row) : 1,
   localparam int BitW     = (CntWidth > 1) ? $clog2(CntWidth) : 1
) (
   input  logic                    readClk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [FrameW-1:0]       frameLen,
   output logic                    shutterA,
   output logic                    shutterB,
   output logic                    loadChain,
   output logic                    shiftEn,
   output logic                    bankSel,
   input  logic [Col-1:0]          serOutA,
   input  logic [Col-1:0]          serOutB,
   output logic [Col*CntWidth-1:0] dataOut,
   output logic [RowW-1:0]         rowIdx,
   output logic [FrameIdW-1:0]     frameId,
   output logic                    dataValid,
   input  logic                    dataReady,
   output logic                    overrun,
   output logic                    busy
);

   ro_state_t             state;
   ro_state_t             nextState;
   logic [BitW-1:0]       bitCnt;
   logic [CntWidth-1:0]   shiftReg [Col];
   logic [Col-1:0]        serSel;
   logic                  lastBit;
   logic                  lastRow;
   logic                  engineIdle;
   logic                  pendingTake;
   logic                  pending;
   bank_t                 pendingBank;

   cont_shutter_timer #(
      .FrameW (FrameW)
   ) shutterTimer (
      .readClk     (readClk),
      .reset       (reset),
      .enable      (enable),
      .frameLen    (frameLen),
      .engineIdle  (engineIdle),
      .pendingTake (pendingTake),
      .shutterA    (shutterA),
      .shutterB    (shutterB),
      .overrun     (overrun),
      .pending     (pending),
      .pendingBank (pendingBank)
   );

   // The deserialisers only ever see the bank that is being read.
   always_comb begin
      serSel  = bankSel ? serOutB : serOutA;
      lastBit = (bitCnt == BitW'(CntWidth - 1));
      lastRow = (rowIdx == RowW'(Row - 1));
   end

   // Engine state register.
   always_ff @(posedge readClk) begin
      if (reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   // Engine sequencing: one load, CntWidth shifts per row, hold each row
   // until it is accepted, and after the last row bump the frame tag.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (pending) nextState = LOAD;
         LOAD:    nextState = SHIFT;
         SHIFT:   if (lastBit) nextState = PRESENT;
         PRESENT: if (dataReady) nextState = lastRow ? DONE : SHIFT;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Engine outputs are pure functions of the state. shiftEn is low while a
   // word is presented, so the chains stall under back-pressure.
   always_comb begin
      loadChain   = (state == LOAD);
      shiftEn     = (state == SHIFT);
      dataValid   = (state == PRESENT);
      engineIdle  = (state == IDLE);
      busy        = (state != IDLE);
      pendingTake = (state == IDLE) && pending;
   end

   // Datapath: bank latch, bit/row counters, frame tag and the per-column
   // MSB-first deserialisers. The shift registers are untouched outside
   // SHIFT, which keeps dataOut stable during PRESENT.
   always_ff @(posedge readClk) begin
      if (reset) begin
         bankSel <= 1'b0;
         bitCnt  <= '0;
         rowIdx  <= '0;
         frameId <= '0;
         for (int c = 0; c < Col; c++)
            shiftReg[c] <= '0;
      end else begin
         case (state)
            IDLE:    if (pending) bankSel <= pendingBank;
            LOAD:    bitCnt <= '0;
            SHIFT: begin
               bitCnt <= lastBit ? '0 : bitCnt + BitW'(1);
               for (int c = 0; c < Col; c++)
                  shiftReg[c] <= {shiftReg[c][CntWidth-2:0], serSel[c]};
            end
            PRESENT: if (dataReady && !lastRow) rowIdx <= rowIdx + RowW'(1);
            DONE: begin
               rowIdx  <= '0;
               frameId <= frameId + FrameIdW'(1);
            end
            default: ;
         endcase
      end
   end

   // Column c occupies dataOut[c*CntWidth +: CntWidth].
   always_comb begin
      dataOut = '0;
      for (int c = 0; c < Col; c++)
         dataOut[c*CntWidth +: CntWidth] = shiftReg[c];
   end

endmodule

// File: tb/tb_cont_readout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cont_readout_ctrl
//    Self-checking bench for cont_readout_ctrl. A pixel-array model fills a
//    bank with counts when its shutter closes and serialises them MSB first,
//    row 0 first, when the engine loads and shifts the chains. Every filled
//    row becomes an expected word in a scoreboard queue, tagged with its bank
//    and a frame number kept modulo 2**FrameIdW.
// -----------------------------------------------------------------------------
module tb_cont_readout_ctrl;

   localparam int Row      = 2;
   localparam int Col      = 2;
   localparam int W        = 4;
   localparam int FrameW   = 16;
   localparam int FrameIdW = 2;

   logic                 readClk = 1'b0;
   logic                 reset;
   logic                 enable;
   logic [FrameW-1:0]    frameLen;
   logic                 shutterA, shutterB, loadChain, shiftEn, bankSel;
   logic [Col-1:0]       serOutA, serOutB;
   logic [Col*W-1:0]     dataOut;
   logic [0:0]           rowIdx;
   logic [FrameIdW-1:0]  frameId;
   logic                 dataValid, dataReady, overrun, busy;

   int testsRun    = 0;
   int testsFailed = 0;

   cont_readout_ctrl #(
      .Row(Row), .Col(Col), .CntWidth(W), .FrameW(FrameW), .FrameIdW(FrameIdW)
   ) dut (
      .readClk(readClk), .reset(reset), .enable(enable), .frameLen(frameLen),
      .shutterA(shutterA), .shutterB(shutterB), .loadChain(loadChain),
      .shiftEn(shiftEn), .bankSel(bankSel), .serOutA(serOutA), .serOutB(serOutB),
      .dataOut(dataOut), .rowIdx(rowIdx), .frameId(frameId),
      .dataValid(dataValid), .dataReady(dataReady), .overrun(overrun), .busy(busy)
   );

   always #5 readClk = ~readClk;

   typedef struct {
      logic             bank;
      logic [Col*W-1:0] word;
      int               row;
      int               fid;
   } expWord_t;

   expWord_t          sb[$];
   expWord_t          head;
   logic [W-1:0]      counts [2][Row][Col];
   logic [W-1:0]      chain  [2][Row][Col];
   int                ptr [2];
   int                cyc = 0;
   int                startCyc [2];
   int                expLen [2];
   int                loadCyc, shutLenNow, fidModel;
   logic              curSh [2];
   logic              prevSh [2];
   logic              prevEnable, prevValid, prevReady, actLoad, actShift, actBank;
   logic              gapPending, gapBank, gapEnable, awaitFirst, firstFrame;
   logic [Col*W-1:0]  prevData, rowWord;
   logic [FrameW-1:0] prevFrameLen = '0;
   logic [W-1:0]      pixVal;

   // Counts every comparison and reports the ones that disagree.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic serBit(input int b, input int c);
      int p = ptr[b];
      if (p >= Row * W)
         return 1'b0;
      return chain[b][p / W][c][W - 1 - (p % W)];
   endfunction

   // Pixel array, scoreboard and protocol checks, all sampled on the falling
   // edge. Chain actions seen in one cycle take effect half a cycle after the
   // rising edge that consumed them, so serOut is steady around every edge.
   always @(negedge readClk) begin
      if (reset) begin
         sb.delete();
         ptr[0] = Row * W; ptr[1] = Row * W;
         prevSh[0] = 0; prevSh[1] = 0;
         prevEnable = 0; prevValid = 0; prevReady = 0;
         actLoad = 0; actShift = 0; actBank = 0;
         gapPending = 0; awaitFirst = 0; fidModel = 0; firstFrame = 1;
         serOutA = '0; serOutB = '0;
      end else begin
         cyc++;
         if (actLoad) begin
            for (int r = 0; r < Row; r++)
               for (int c = 0; c < Col; c++)
                  chain[actBank][r][c] = counts[actBank][r][c];
            ptr[actBank] = 0;
         end
         if (actShift)
            ptr[actBank]++;
         for (int c = 0; c < Col; c++) begin
            serOutA[c] = serBit(0, c);
            serOutB[c] = serBit(1, c);
         end

         checkOutput("shutterExclusive", shutterA & shutterB, 0);
         if (gapPending) begin
            checkOutput("swapRise", gapBank ? shutterB : shutterA, gapEnable);
            gapPending = 0;
         end
         if ((prevSh[0] || prevSh[1]) && !prevEnable)
            checkOutput("enableDrop", shutterA | shutterB, 0);

         curSh[0] = shutterA;
         curSh[1] = shutterB;
         for (int b = 0; b < 2; b++) begin
            if (!prevSh[b] && curSh[b]) begin
               startCyc[b] = cyc;
               expLen[b]   = (prevFrameLen < 2) ? 2 : int'(prevFrameLen);
            end
            if (prevSh[b] && !curSh[b]) begin
               shutLenNow = cyc - startCyc[b];
               if (prevEnable) begin
                  if (overrun)
                     checkOutput("heldLen", shutLenNow >= expLen[b], 1);
                  else
                     checkOutput("shutLen", shutLenNow, expLen[b]);
                  checkOutput("deadCycle", shutterA | shutterB, 0);
                  gapPending = 1;
                  gapBank    = (b == 0);
                  gapEnable  = enable;
               end
               for (int r = 0; r < Row; r++) begin
                  rowWord = '0;
                  for (int c = 0; c < Col; c++) begin
                     if (firstFrame)
                        pixVal = (c % 2 == 0) ? 4'hA : 4'h5;
                     else
                        pixVal = W'($urandom);
                     counts[b][r][c] = pixVal;
                     rowWord[c*W +: W] = pixVal;
                  end
                  sb.push_back('{bank: 1'(b), word: rowWord, row: r, fid: fidModel});
               end
               fidModel   = (fidModel + 1) % (1 << FrameIdW);
               firstFrame = 0;
            end
         end

         if (dataValid && dataReady) begin
            if (sb.size() == 0) begin
               checkOutput("unexpectedWord", 1, 0);
            end else begin
               head = sb.pop_front();
               checkOutput("dataOut", dataOut, head.word);
               checkOutput("rowIdx", rowIdx, head.row);
               checkOutput("frameId", frameId, head.fid);
               checkOutput("bankSel", bankSel, head.bank);
            end
         end
         if (prevValid && !prevReady) begin
            checkOutput("holdValid", dataValid, 1);
            checkOutput("holdData", dataOut, prevData);
         end
         if (dataValid)
            checkOutput("stallShift", shiftEn, 0);
         if (loadChain) begin
            loadCyc    = cyc;
            awaitFirst = 1;
         end else if (dataValid && awaitFirst) begin
            checkOutput("firstLatency", cyc - loadCyc, W + 1);
            awaitFirst = 0;
         end

         actLoad    = loadChain;
         actShift   = shiftEn;
         actBank    = bankSel;
         prevSh[0]  = shutterA;
         prevSh[1]  = shutterB;
         prevEnable = enable;
         prevValid  = dataValid;
         prevReady  = dataReady;
         prevData   = dataOut;
      end
      prevFrameLen = frameLen;
   end

   // Drives enable, a random frameLen in [lenLo, lenHi] and a random
   // dataReady for a number of cycles, changing inputs just after each edge.
   task automatic applyStimulus(input logic en, input int lenLo, input int lenHi,
                                input int readyPct, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge readClk);
         #1;
         enable    = en;
         frameLen  = FrameW'($urandom_range(lenHi, lenLo));
         dataReady = ($urandom_range(0, 99) < readyPct);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".shutterA"}, shutterA, 0);
      checkOutput({tag, ".shutterB"}, shutterB, 0);
      checkOutput({tag, ".loadChain"}, loadChain, 0);
      checkOutput({tag, ".shiftEn"}, shiftEn, 0);
      checkOutput({tag, ".bankSel"}, bankSel, 0);
      checkOutput({tag, ".dataOut"}, dataOut, 0);
      checkOutput({tag, ".rowIdx"}, rowIdx, 0);
      checkOutput({tag, ".frameId"}, frameId, 0);
      checkOutput({tag, ".dataValid"}, dataValid, 0);
      checkOutput({tag, ".overrun"}, overrun, 0);
      checkOutput({tag, ".busy"}, busy, 0);
   endtask

   // Waits, bounded, until the engine has stayed idle for several cycles.
   task automatic waitQuiet(input string tag);
      int quiet = 0;
      for (int i = 0; i < 3000 && quiet < 4; i++) begin
         @(negedge readClk);
         quiet = busy ? 0 : quiet + 1;
      end
      checkOutput(tag, quiet >= 4, 1);
   endtask

   initial begin
      int found;
      reset     = 1'b1;
      enable    = 1'b0;
      frameLen  = FrameW'(40);
      dataReady = 1'b1;
      repeat (3) @(posedge readClk);
      @(negedge readClk);
      checkAllZero("reset");
      @(posedge readClk);
      #1 reset = 1'b0;

      // Steady acquisition with a fixed 40-cycle exposure, sink always ready.
      applyStimulus(1'b1, 40, 40, 100, 100);

      // Back-pressure for 10 cycles on row 0 of the next frame.
      dataReady = 1'b0;
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge readClk);
         if (dataValid && rowIdx == 1'b0) found = 1;
      end
      checkOutput("stallWait", found, 1);
      repeat (10) @(posedge readClk);
      #1 dataReady = 1'b1;
      applyStimulus(1'b1, 40, 40, 100, 60);

      // Exposures far shorter than a readout: swaps must be held.
      applyStimulus(1'b1, 6, 6, 75, 300);
      @(negedge readClk);
      checkOutput("overrunSet", overrun, 1);

      // Random exposure lengths, then stop during a bank B exposure.
      applyStimulus(1'b1, 20, 60, 70, 200);
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge readClk);
         if (shutterB) found = 1;
      end
      checkOutput("shutterBWait", found, 1);
      @(posedge readClk);
      #1 enable = 1'b0;
      dataReady = 1'b1;
      @(negedge readClk);
      @(negedge readClk);
      checkOutput("shutterBDrop", shutterB, 0);
      waitQuiet("drainStop");
      checkOutput("stopShutterA", shutterA, 0);
      checkOutput("stopShutterB", shutterB, 0);
      checkOutput("overrunCleared", overrun, 0);
      checkOutput("stopWordsLeft", sb.size(), 0);

      // Reset in the middle of shifting row 1, then restart.
      enable   = 1'b1;
      frameLen = FrameW'(20);
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge readClk);
         if (shiftEn && rowIdx == 1'b1) found = 1;
      end
      checkOutput("row1ShiftWait", found, 1);
      @(posedge readClk);
      #1 reset = 1'b1;
      @(posedge readClk);
      @(negedge readClk);
      checkAllZero("midReset");
      @(posedge readClk);
      #1 reset = 1'b0;
      @(negedge readClk);
      @(negedge readClk);
      checkOutput("restartA", shutterA, 1);
      applyStimulus(1'b1, 20, 20, 80, 150);

      // frameLen of 0 and 1 behave as 2; enough frames to wrap the tag.
      applyStimulus(1'b1, 0, 1, 80, 400);
      @(posedge readClk);
      #1 enable = 1'b0;
      dataReady = 1'b1;
      waitQuiet("drainFinal");
      checkOutput("finalShutters", shutterA | shutterB, 0);
      checkOutput("finalWordsLeft", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
